// File: rtl/multi_lane_ber_monitor_pkg.sv
// multi_lane_ber_monitor_pkg: lane state encodings, parameter defaults and popcount helper
package multi_lane_ber_monitor_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'b001,
        TEST   = 3'b010,
        HI_BER = 3'b100
    } lane_state_t;

    localparam int DEF_HI_BER_VALUE  = 97;
    localparam int DEF_WINDOW_BLOCKS = 4096;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/multi_lane_ber_monitor_lane.sv
// ber_lane_monitor: per-lane window timer, error counter and hi_ber state machine
module ber_lane_monitor
    import multi_lane_ber_monitor_pkg::*;
#(
    parameter int HI_BER_VALUE  = DEF_HI_BER_VALUE,
    parameter int WINDOW_BLOCKS = DEF_WINDOW_BLOCKS
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_valid,
    input  logic i_valid_sh,
    input  logic i_deskew_done,
    input  logic i_test_mode,
    output logic o_hi_ber
);
    localparam int NB_WIN = $clog2(WINDOW_BLOCKS);
    localparam int NB_ERR = $clog2(HI_BER_VALUE + 1);

    lane_state_t state, state_next;
    logic [NB_WIN-1:0] timer, timer_next;
    logic [NB_ERR-1:0] cnt, cnt_next, cnt_incl;
    logic hi_ber_next, err, win_end, hit;

    always_comb begin
        err         = i_valid & ~i_valid_sh;
        cnt_incl    = (err && cnt != NB_ERR'(HI_BER_VALUE)) ? cnt + 1'b1 : cnt;
        win_end     = timer == NB_WIN'(WINDOW_BLOCKS - 1);
        hit         = cnt_incl == NB_ERR'(HI_BER_VALUE);
        state_next  = state;
        timer_next  = timer;
        cnt_next    = cnt;
        hi_ber_next = o_hi_ber;
        if (!i_deskew_done) begin
            state_next  = INIT;
            timer_next  = '0;
            cnt_next    = '0;
            hi_ber_next = 1'b0;
        end else if (i_test_mode) begin
            // error count is held; the window restarts when test mode ends
            state_next  = TEST;
            timer_next  = '0;
            hi_ber_next = 1'b0;
        end else if (i_valid) begin
            if (state == INIT) begin
                state_next = TEST;
            end else if (win_end) begin
                state_next  = hit ? HI_BER : TEST;
                hi_ber_next = hit;
                timer_next  = '0;
                cnt_next    = '0;
            end else begin
                timer_next = timer + 1'b1;
                cnt_next   = cnt_incl;
                if (hit) begin
                    state_next  = HI_BER;
                    hi_ber_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= INIT;
            timer    <= '0;
            cnt      <= '0;
            o_hi_ber <= 1'b0;
        end else begin
            state    <= state_next;
            timer    <= timer_next;
            cnt      <= cnt_next;
            o_hi_ber <= hi_ber_next;
        end
    end

endmodule

// File: rtl/multi_lane_ber_monitor.sv
// multi_lane_ber_monitor: per-lane hi-BER flags plus aggregate flag and error count.
// Define BER_MONITOR_MGMT_COUNT_EN to build the saturating management error counter.
module multi_lane_ber_monitor
    import multi_lane_ber_monitor_pkg::*;
#(
    parameter int N_LANES       = 20,
    parameter int HI_BER_VALUE  = DEF_HI_BER_VALUE,
    parameter int WINDOW_BLOCKS = DEF_WINDOW_BLOCKS,
    parameter int NB_BER_COUNT  = 22
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [N_LANES-1:0]      i_valid,
    input  logic [N_LANES-1:0]      i_valid_sh,
    input  logic                    i_deskew_done,
    input  logic                    i_test_mode,
    input  logic                    i_ber_count_clr,
    output logic [N_LANES-1:0]      o_lane_hi_ber,
    output logic                    o_hi_ber,
    output logic [NB_BER_COUNT-1:0] o_ber_count
);

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        ber_lane_monitor #(
            .HI_BER_VALUE (HI_BER_VALUE),
            .WINDOW_BLOCKS(WINDOW_BLOCKS)
        ) u_lane (
            .i_clock      (i_clock),
            .i_reset      (i_reset),
            .i_valid      (i_valid[k]),
            .i_valid_sh   (i_valid_sh[k]),
            .i_deskew_done(i_deskew_done),
            .i_test_mode  (i_test_mode),
            .o_hi_ber     (o_lane_hi_ber[k])
        );
    end

    assign o_hi_ber = |o_lane_hi_ber;

`ifdef BER_MONITOR_MGMT_COUNT_EN
    localparam int NB_POP = $clog2(N_LANES + 1);
    localparam int NB1    = NB_BER_COUNT + 1;

    logic [31:0]             events;
    logic [NB_POP-1:0]       pop;
    logic [NB1-1:0]          sum;
    logic [NB_BER_COUNT-1:0] count_next;

    always_comb begin
        events                = '0;
        events[N_LANES-1:0]   = i_valid & ~i_valid_sh;
        pop                   = NB_POP'(popcount(events));
        sum                   = {1'b0, o_ber_count} + NB1'(pop);
        // the clear loads this cycle's errors so none are dropped
        count_next            = i_ber_count_clr ? NB_BER_COUNT'(pop)
                              : sum[NB_BER_COUNT] ? '1 : sum[NB_BER_COUNT-1:0];
    end

    always_ff @(posedge i_clock) begin
        o_ber_count <= i_reset ? '0 : count_next;
    end
`else
    logic unused_clr;
    assign unused_clr  = i_ber_count_clr;
    assign o_ber_count = '0;
`endif

endmodule

// File: tb/tb_multi_lane_ber_monitor.sv
// tb_multi_lane_ber_monitor: directed vectors and window corner-case sequences
module tb_multi_lane_ber_monitor;

    localparam int NL = 20;
    localparam int WB = 256;
`ifdef BER_MONITOR_MGMT_COUNT_EN
    localparam int MG = 1;
`else
    localparam int MG = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, deskew, tm, clr;
    logic [NL-1:0] valid, sh, lane_hi;
    logic          hi;
    logic [5:0]    cnt;
    int            errors = 0, checks = 0;
    logic          seen;
    logic [NL-1:0] l3 = 20'h8;

    always #5 clk = ~clk;

    multi_lane_ber_monitor #(
        .N_LANES(NL), .HI_BER_VALUE(97), .WINDOW_BLOCKS(WB), .NB_BER_COUNT(6)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_valid_sh(sh),
        .i_deskew_done(deskew), .i_test_mode(tm), .i_ber_count_clr(clr),
        .o_lane_hi_ber(lane_hi), .o_hi_ber(hi), .o_ber_count(cnt)
    );

    typedef struct {
        logic [NL-1:0] valid;
        logic [NL-1:0] sh;
        logic          clr;
        logic [5:0]    cnt;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input logic [NL-1:0] err);
        valid = '1;
        sh    = ~err;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; sh = '1; deskew = 1'b1; tm = 1'b0; clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tv[0] = '{'1, '0, 1'b0, 6'd20};
        tv[1] = '{'1, '0, 1'b0, 6'd40};
        tv[2] = '{'1, '0, 1'b1, 6'd20};
        tv[3] = '{'1, '0, 1'b0, 6'd40};
        tv[4] = '{'1, '0, 1'b0, 6'd60};
        tv[5] = '{'1, '0, 1'b0, 6'd63};
        tv[6] = '{'1, '0, 1'b0, 6'd63};
        tv[7] = '{'0, '0, 1'b0, 6'd63};
        tv[8] = '{20'h1, '0, 1'b1, 6'd1};
        tv[9] = '{'1, '1, 1'b0, 6'd1};

        do_reset();
        chk("rst_flags", 32'(lane_hi), 0);
        chk("rst_hi", 32'(hi), 0);
        chk("rst_cnt", 32'(cnt), 0);

        // error-free for three windows
        seen = 1'b0;
        for (int b = 0; b < 3 * WB + 1; b++) begin
            blk('0);
            seen |= hi;
        end
        chk("clean_hi", 32'(seen), 0);
        chk("clean_cnt", 32'(cnt), 0);

        // all-lane errors, count clear and saturation
        do_reset();
        for (int i = 0; i < 10; i++) begin
            valid = tv[i].valid;
            sh    = tv[i].sh;
            clr   = tv[i].clr;
            tick();
            chk($sformatf("vec%0d_flags", i), 32'(lane_hi), 0);
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), MG * 32'(tv[i].cnt));
        end
        clr = 1'b0;

        // lane 3: set on 97th error, held over window end, cleared after a window of 96
        do_reset();
        blk('0);
        for (int b = 0; b < WB; b++) begin
            blk(b < 97 ? l3 : '0);
            if (b == 95) chk("l3_pre", 32'(lane_hi), 0);
            if (b == 96) begin
                chk("l3_set", 32'(lane_hi), 32'(l3));
                chk("l3_set_hi", 32'(hi), 1);
            end
            if (b == WB - 1) chk("l3_hold", 32'(lane_hi), 32'(l3));
        end
        for (int b = 0; b < WB; b++) begin
            blk(b < 96 ? l3 : '0);
            if (b == WB - 2) chk("l3_stay", 32'(lane_hi), 32'(l3));
            if (b == WB - 1) begin
                chk("l3_clear", 32'(lane_hi), 0);
                chk("l3_clear_hi", 32'(hi), 0);
            end
        end

        // 97th error lands on the window's last block
        do_reset();
        blk('0);
        for (int b = 0; b < WB; b++) begin
            blk(b >= WB - 97 ? l3 : '0);
            if (b == WB - 2) chk("last_pre", 32'(lane_hi), 0);
            if (b == WB - 1) chk("last_set", 32'(lane_hi), 32'(l3));
        end
        for (int b = 0; b < WB; b++) begin
            blk('0);
            if (b == WB - 2) chk("last_hold", 32'(lane_hi), 32'(l3));
            if (b == WB - 1) chk("last_clear", 32'(lane_hi), 0);
        end

        // deskew loss drops flags; the INIT->TEST block is not counted
        do_reset();
        blk('0);
        for (int b = 0; b < 97; b++) blk(l3);
        chk("dsk_set", 32'(lane_hi), 32'(l3));
        deskew = 1'b0;
        blk(l3);
        chk("dsk_drop", 32'(lane_hi), 0);
        chk("dsk_drop_hi", 32'(hi), 0);
        deskew = 1'b1;
        blk(l3);
        for (int b = 0; b < 96; b++) blk(l3);
        chk("dsk_96", 32'(lane_hi), 0);
        blk(l3);
        chk("dsk_97", 32'(lane_hi), 32'(l3));

        // test mode: flags forced low, timer frozen, mgmt count running
        do_reset();
        blk('0);
        for (int b = 0; b < 10; b++) blk('0);
        tm  = 1'b1;
        clr = 1'b1;
        blk('1);
        clr = 1'b0;
        chk("tm_cnt1", 32'(cnt), MG * 20);
        blk('1);
        chk("tm_cnt2", 32'(cnt), MG * 40);
        seen = 1'b0;
        for (int b = 0; b < 200; b++) begin
            blk('1);
            seen |= hi;
        end
        chk("tm_flags", 32'(seen), 0);
        chk("tm_cnt_sat", 32'(cnt), MG * 63);
        tm = 1'b0;
        for (int b = 0; b < WB; b++) begin
            blk(b >= WB - 97 ? l3 : '0);
            if (b == WB - 2) chk("tm_exit_pre", 32'(lane_hi), 0);
            if (b == WB - 1) chk("tm_exit_end", 32'(lane_hi), 32'(l3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
